dmc_param_cache: RTL and testbench

Parametrised direct-mapped cache sitting between the MANO CPU datapath and main memory, successor to the fixed 256-line, 16-bit direct-mapped cache. Width, address size and line count are parameters. A proper request/ready handshake on both sides replaces single-cycle assumptions about memory. The cache supports selectable write-back/write-allocate or write-through/no-allocate policy, and a full-cache flush command that writes back dirty lines.

---
 rtl/dmc_param_cache.sv | 252 +++++++++++++++++++++++++
 tb/tb_dmc_param_cache.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmc_param_cache.sv
// Parametrised direct-mapped cache, one word per line, between the CPU datapath
// and main memory. Request/ready handshakes on both sides; write-back/allocate
// or write-through/no-allocate chosen by WB_MODE; full-cache flush command.
module dmc_param_cache #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned INDEX_W = 8,
    parameter bit          WB_MODE = 1'b1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cache_hit,
    input  logic              flush,
    output logic              flush_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W;
    localparam int unsigned LINES = 2 ** INDEX_W;

    typedef enum logic [2:0] {
        S_IDLE, S_WBACK, S_FILL, S_WTHRU, S_RESP, S_FL_SCAN, S_FL_WB
    } state_t;

    state_t             state_q, state_d;
    logic [INDEX_W-1:0] fl_idx_q, fl_idx_d;

    logic [LINES-1:0]   valid_q, dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [DATA_W-1:0]  data_q [LINES];

    logic [DATA_W-1:0]  cpu_rdata_d, mem_wdata_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic               cpu_ready_d, cache_hit_d, flush_done_d, mem_req_d, mem_we_d;

    logic               upd_en, upd_valid, upd_dirty, tag_en, data_en;
    logic [INDEX_W-1:0] upd_idx;
    logic [DATA_W-1:0]  upd_data;

    logic [INDEX_W-1:0] cpu_idx;
    logic [TAG_W-1:0]   cpu_tag;
    logic               lookup_hit, victim_dirty, line_dirty, fl_last, ack;

    // Lookup of the line addressed by the CPU and of the flush cursor line
    assign cpu_idx      = cpu_addr[INDEX_W-1:0];
    assign cpu_tag      = cpu_addr[ADDR_W-1:INDEX_W];
    assign lookup_hit   = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    assign victim_dirty = valid_q[cpu_idx] && dirty_q[cpu_idx];
    assign line_dirty   = valid_q[fl_idx_q] && dirty_q[fl_idx_q];
    assign fl_last      = (fl_idx_q == {INDEX_W{1'b1}});
    assign ack          = mem_req && mem_ack;

    // Next-state, next-output and line-update decode
    always_comb begin
        state_d      = state_q;
        fl_idx_d     = fl_idx_q;
        cpu_rdata_d  = cpu_rdata;
        cpu_ready_d  = 1'b0;
        cache_hit_d  = cache_hit;
        flush_done_d = 1'b0;
        mem_req_d    = mem_req;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        upd_en       = 1'b0;
        upd_valid    = 1'b0;
        upd_dirty    = 1'b0;
        tag_en       = 1'b0;
        data_en      = 1'b0;
        upd_idx      = cpu_idx;
        upd_data     = cpu_wdata;

        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d  = S_FL_SCAN;
                    fl_idx_d = '0;
                end else if (cpu_req) begin
                    cache_hit_d = lookup_hit;
                    if (!cpu_we) begin
                        if (lookup_hit) begin
                            cpu_rdata_d = data_q[cpu_idx];
                            cpu_ready_d = 1'b1;
                            state_d     = S_RESP;
                        end else if (victim_dirty) begin
                            state_d     = S_WBACK;
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = {tag_q[cpu_idx], cpu_idx};
                            mem_wdata_d = data_q[cpu_idx];
                        end else begin
                            state_d    = S_FILL;
                            mem_req_d  = 1'b1;
                            mem_we_d   = 1'b0;
                            mem_addr_d = cpu_addr;
                        end
                    end else if (WB_MODE) begin
                        if (!lookup_hit && victim_dirty) begin
                            state_d     = S_WBACK;
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = {tag_q[cpu_idx], cpu_idx};
                            mem_wdata_d = data_q[cpu_idx];
                        end else begin
                            // hit or clean victim: a one-word line needs no fill
                            upd_en      = 1'b1;
                            upd_valid   = 1'b1;
                            upd_dirty   = 1'b1;
                            tag_en      = 1'b1;
                            data_en     = 1'b1;
                            cpu_ready_d = 1'b1;
                            state_d     = S_RESP;
                        end
                    end else begin
                        data_en     = lookup_hit;
                        state_d     = S_WTHRU;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                    end
                end
            end
            S_WBACK: begin
                if (ack) begin
                    upd_en    = 1'b1;
                    upd_valid = 1'b1;
                    upd_dirty = 1'b0;
                    if (!cpu_we) begin
                        state_d    = S_FILL;
                        mem_we_d   = 1'b0;
                        mem_addr_d = cpu_addr;
                    end else begin
                        upd_dirty   = 1'b1;
                        tag_en      = 1'b1;
                        data_en     = 1'b1;
                        cpu_ready_d = 1'b1;
                        mem_req_d   = 1'b0;
                        state_d     = S_RESP;
                    end
                end
            end
            S_FILL: begin
                if (ack) begin
                    upd_en      = 1'b1;
                    upd_valid   = 1'b1;
                    tag_en      = 1'b1;
                    data_en     = 1'b1;
                    upd_data    = mem_rdata;
                    cpu_rdata_d = mem_rdata;
                    cpu_ready_d = 1'b1;
                    mem_req_d   = 1'b0;
                    state_d     = S_RESP;
                end
            end
            S_WTHRU: begin
                if (ack) begin
                    cpu_ready_d = 1'b1;
                    mem_req_d   = 1'b0;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            S_FL_SCAN: begin
                upd_idx = fl_idx_q;
                if (line_dirty) begin
                    state_d     = S_FL_WB;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {tag_q[fl_idx_q], fl_idx_q};
                    mem_wdata_d = data_q[fl_idx_q];
                end else begin
                    upd_en = 1'b1;
                    if (fl_last) begin
                        flush_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        fl_idx_d = fl_idx_q + INDEX_W'(1);
                    end
                end
            end
            S_FL_WB: begin
                upd_idx = fl_idx_q;
                if (ack) begin
                    upd_en    = 1'b1;
                    mem_req_d = 1'b0;
                    if (fl_last) begin
                        flush_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        fl_idx_d = fl_idx_q + INDEX_W'(1);
                        state_d  = S_FL_SCAN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, line status bits and registered outputs
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            fl_idx_q   <= '0;
            valid_q    <= '0;
            dirty_q    <= '0;
            cpu_rdata  <= '0;
            cpu_ready  <= 1'b0;
            cache_hit  <= 1'b0;
            flush_done <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state_q    <= state_d;
            fl_idx_q   <= fl_idx_d;
            if (upd_en) begin
                valid_q[upd_idx] <= upd_valid;
                dirty_q[upd_idx] <= upd_dirty;
            end
            cpu_rdata  <= cpu_rdata_d;
            cpu_ready  <= cpu_ready_d;
            cache_hit  <= cache_hit_d;
            flush_done <= flush_done_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
        end
    end

    // Tag and data storage; contents are meaningless until valid is set
    always_ff @(posedge clk) begin
        if (tag_en)  tag_q[upd_idx]  <= cpu_tag;
        if (data_en) data_q[upd_idx] <= upd_data;
    end

endmodule

// File: tb/tb_dmc_param_cache.sv
// Self-checking bench: instance 0 is write-back, instance 1 write-through.
// Reference: coherent shadow memory plus a per-line tag/valid/dirty view.
module tb_dmc_param_cache;

    logic        clk = 1'b0;
    logic        clr;
    logic        cpu_req   [2];
    logic        cpu_we    [2];
    logic [11:0] cpu_addr  [2];
    logic [15:0] cpu_wdata [2];
    logic [15:0] cpu_rdata [2];
    logic        cpu_ready [2];
    logic        cache_hit [2];
    logic        flush     [2];
    logic        flush_done[2];
    logic        mem_req   [2];
    logic        mem_we    [2];
    logic [11:0] mem_addr  [2];
    logic [15:0] mem_wdata [2];
    logic [15:0] mem_rdata [2];
    logic        mem_ack   [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmc_param_cache #(
            .ADDR_W(12), .DATA_W(16), .INDEX_W(8),
            .WB_MODE((g == 0) ? 1'b1 : 1'b0)
        ) u_dut (
            .clk(clk), .clr(clr),
            .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
            .cpu_wdata(cpu_wdata[g]), .cpu_rdata(cpu_rdata[g]), .cpu_ready(cpu_ready[g]),
            .cache_hit(cache_hit[g]), .flush(flush[g]), .flush_done(flush_done[g]),
            .mem_req(mem_req[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .mem_ack(mem_ack[g])
        );
    end

    function automatic logic [15:0] init_val(int g, logic [11:0] a);
        if (a == 12'h123) return 16'hBEEF;
        return (16'(a) * 16'd409) ^ ((g == 0) ? 16'h7070 : 16'h0F0F);
    endfunction

    function automatic logic [29:0] op(int g, bit we, logic [11:0] a, logic [15:0] d);
        return {1'(g), we, a, d};
    endfunction

    // Memory responder: random ack latency, logs every completed operation
    bit [15:0]   mem_arr [2][4096];
    bit          mem_wr  [2][4096];
    int          cnt [2];
    int          lat [2];
    bit          act [2];
    logic [28:0] held [2];
    int          stab_err = 0;
    logic [29:0] oplog [$];

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!clr || mem_ack[g] || !mem_req[g]) begin
                mem_ack[g] <= 1'b0;
                act[g]     <= 1'b0;
                cnt[g]     <= 0;
            end else begin
                if (act[g] && ({mem_we[g], mem_addr[g], mem_wdata[g]} !== held[g]))
                    stab_err <= stab_err + 1;
                act[g]  <= 1'b1;
                held[g] <= {mem_we[g], mem_addr[g], mem_wdata[g]};
                if (cnt[g] >= lat[g]) begin
                    mem_ack[g] <= 1'b1;
                    cnt[g]     <= 0;
                    lat[g]     <= int'($urandom_range(0, 3));
                    if (mem_we[g]) begin
                        mem_arr[g][mem_addr[g]] <= mem_wdata[g];
                        mem_wr[g][mem_addr[g]]  <= 1'b1;
                        oplog.push_back(op(g, 1'b1, mem_addr[g], mem_wdata[g]));
                    end else begin
                        mem_rdata[g] <= mem_wr[g][mem_addr[g]] ? mem_arr[g][mem_addr[g]]
                                                               : init_val(g, mem_addr[g]);
                        oplog.push_back(op(g, 1'b0, mem_addr[g], 16'h0));
                    end
                end else begin
                    cnt[g] <= cnt[g] + 1;
                end
            end
        end
    end

    // Reference model: latest CPU-visible value per address, and line residency
    logic [15:0] sh_val [2][4096];
    bit          sh_wr  [2][4096];
    bit          m_valid [2][256];
    bit          m_dirty [2][256];
    logic [3:0]  m_tag   [2][256];
    logic [29:0] exp_ops [$];

    function automatic logic [15:0] sh_rd(int g, logic [11:0] a);
        return sh_wr[g][a] ? sh_val[g][a] : init_val(g, a);
    endfunction

    task automatic model_reset();
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 256; i++) begin
                m_valid[g][i] = 1'b0;
                m_dirty[g][i] = 1'b0;
            end
    endtask

    task automatic model_access(input int g, input bit we, input logic [11:0] a,
                                input logic [15:0] d, output logic eh, output logic [15:0] er);
        int i = int'(a[7:0]);
        bit wb = (g == 0);
        exp_ops.delete();
        eh = m_valid[g][i] && (m_tag[g][i] == a[11:8]);
        er = sh_rd(g, a);
        if (!eh && m_valid[g][i] && m_dirty[g][i] && (wb || !we))
            exp_ops.push_back(op(g, 1'b1, {m_tag[g][i], a[7:0]}, sh_rd(g, {m_tag[g][i], a[7:0]})));
        if (!we) begin
            if (!eh) begin
                exp_ops.push_back(op(g, 1'b0, a, 16'h0));
                m_valid[g][i] = 1'b1;
                m_dirty[g][i] = 1'b0;
                m_tag[g][i]   = a[11:8];
            end
        end else begin
            if (wb) begin
                m_valid[g][i] = 1'b1;
                m_dirty[g][i] = 1'b1;
                m_tag[g][i]   = a[11:8];
            end else begin
                exp_ops.push_back(op(g, 1'b1, a, d));
            end
            sh_val[g][a] = d;
            sh_wr[g][a]  = 1'b1;
        end
    endtask

    task automatic model_flush(input int g);
        exp_ops.delete();
        for (int i = 0; i < 256; i++) begin
            if (m_valid[g][i] && m_dirty[g][i])
                exp_ops.push_back(op(g, 1'b1, {m_tag[g][i], 8'(i)}, sh_rd(g, {m_tag[g][i], 8'(i)})));
            m_valid[g][i] = 1'b0;
            m_dirty[g][i] = 1'b0;
        end
    endtask

    // Stimulus drivers returning observations (cyc = -1 on timeout)
    task automatic do_access(input int g, input bit we, input logic [11:0] a, input logic [15:0] d,
                             output logic [15:0] rd, output logic hit, output int cyc);
        @(negedge clk);
        oplog.delete();
        cpu_we[g] = we; cpu_addr[g] = a; cpu_wdata[g] = d; cpu_req[g] = 1'b1;
        cyc = -1; rd = '0; hit = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (cpu_ready[g]) begin
                cyc = i; rd = cpu_rdata[g]; hit = cache_hit[g];
                break;
            end
        end
        cpu_req[g] = 1'b0;
    endtask

    task automatic do_flush(input int g, output int cyc, output int pulses);
        @(negedge clk);
        oplog.delete();
        flush[g] = 1'b1; cyc = -1; pulses = 0;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk);
            if (flush_done[g]) begin cyc = i; pulses++; break; end
        end
        flush[g] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (flush_done[g]) pulses++;
        end
    endtask

    task automatic test_reset();
        for (int g = 0; g < 2; g++) begin
            cpu_req[g] = 0; cpu_we[g] = 0; cpu_addr[g] = 0; cpu_wdata[g] = 0; flush[g] = 0;
        end
        clr = 1'b1;
        #3 clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({cpu_rdata[g], cpu_ready[g], cache_hit[g], flush_done[g], mem_req[g], mem_we[g],
                 mem_addr[g], mem_wdata[g]} !== 62'h0) begin
                errors++;
                $display("FAIL reset_outputs g=%0d got rdata=%h rdy=%b hit=%b fd=%b req=%b we=%b addr=%h wd=%h required all 0",
                         g, cpu_rdata[g], cpu_ready[g], cache_hit[g], flush_done[g], mem_req[g],
                         mem_we[g], mem_addr[g], mem_wdata[g]);
            end
        end
        clr = 1'b1;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({cpu_ready[g], mem_req[g], flush_done[g]} !== 3'b000) begin
                errors++;
                $display("FAIL idle_after_reset g=%0d got rdy/req/fd=%b%b%b required 000",
                         g, cpu_ready[g], mem_req[g], flush_done[g]);
            end
        end
    endtask

    task automatic test_read_miss_hit();
        logic [15:0] rd, er; logic hit, eh; int cyc;
        model_access(0, 1'b0, 12'h123, 16'h0, eh, er);
        do_access(0, 1'b0, 12'h123, 16'h0, rd, hit, cyc);
        checks++; if (cyc < 0) begin errors++; $display("FAIL rmiss_timeout got cyc=%0d required >0", cyc); end
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL rmiss_data got %h required beef", rd); end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rmiss_hit got %b required 0", hit); end
        checks++; if (oplog.size() != 1 || oplog[0] !== op(0, 1'b0, 12'h123, 16'h0)) begin
            errors++; $display("FAIL rmiss_ops got n=%0d first=%h required one read of 123", oplog.size(), oplog[0]);
        end
        model_access(0, 1'b0, 12'h123, 16'h0, eh, er);
        do_access(0, 1'b0, 12'h123, 16'h0, rd, hit, cyc);
        checks++; if (cyc != 1) begin errors++; $display("FAIL rhit_latency got %0d required 1", cyc); end
        checks++; if (hit !== 1'b1 || rd !== 16'hBEEF) begin
            errors++; $display("FAIL rhit_result got hit=%b data=%h required hit=1 data=beef", hit, rd);
        end
        checks++; if (oplog.size() != 0) begin errors++; $display("FAIL rhit_ops got %0d mem ops required 0", oplog.size()); end
    endtask

    task automatic test_wb_alloc();
        logic [15:0] rd, er; logic hit, eh; int cyc;
        model_access(0, 1'b1, 12'h045, 16'h1111, eh, er);
        do_access(0, 1'b1, 12'h045, 16'h1111, rd, hit, cyc);
        checks++; if (hit !== 1'b0 || cyc != 1) begin
            errors++; $display("FAIL wb_write_miss got hit=%b cyc=%0d required hit=0 cyc=1", hit, cyc);
        end
        checks++; if (oplog.size() != 0) begin errors++; $display("FAIL wb_write_miss_ops got %0d required 0", oplog.size()); end
        model_access(0, 1'b0, 12'h145, 16'h0, eh, er);
        do_access(0, 1'b0, 12'h145, 16'h0, rd, hit, cyc);
        checks++; if (oplog.size() != 2 || oplog[0] !== op(0, 1'b1, 12'h045, 16'h1111)
                      || oplog[1] !== op(0, 1'b0, 12'h145, 16'h0)) begin
            errors++; $display("FAIL wb_evict_ops got n=%0d %h %h required wr 045=1111 then rd 145",
                               oplog.size(), oplog[0], oplog[1]);
        end
        checks++; if (hit !== 1'b0 || rd !== init_val(0, 12'h145)) begin
            errors++; $display("FAIL wb_evict_read got hit=%b data=%h required hit=0 data=%h", hit, rd, init_val(0, 12'h145));
        end
    endtask

    task automatic test_wt();
        logic [15:0] rd, er; logic hit, eh; int cyc;
        model_access(1, 1'b0, 12'h010, 16'h0, eh, er);
        do_access(1, 1'b0, 12'h010, 16'h0, rd, hit, cyc);
        checks++; if (hit !== 1'b0 || rd !== init_val(1, 12'h010) || oplog.size() != 1) begin
            errors++; $display("FAIL wt_fill got hit=%b data=%h ops=%0d required 0 %h 1", hit, rd, oplog.size(), init_val(1, 12'h010));
        end
        model_access(1, 1'b1, 12'h010, 16'hAAAA, eh, er);
        do_access(1, 1'b1, 12'h010, 16'hAAAA, rd, hit, cyc);
        checks++; if (hit !== 1'b1 || oplog.size() != 1 || oplog[0] !== op(1, 1'b1, 12'h010, 16'hAAAA)) begin
            errors++; $display("FAIL wt_write_hit got hit=%b ops=%0d first=%h required hit=1 one wr 010=aaaa", hit, oplog.size(), oplog[0]);
        end
        model_access(1, 1'b1, 12'h210, 16'h5555, eh, er);
        do_access(1, 1'b1, 12'h210, 16'h5555, rd, hit, cyc);
        checks++; if (hit !== 1'b0 || oplog.size() != 1 || oplog[0] !== op(1, 1'b1, 12'h210, 16'h5555)) begin
            errors++; $display("FAIL wt_write_miss got hit=%b ops=%0d first=%h required hit=0 one wr 210=5555", hit, oplog.size(), oplog[0]);
        end
        model_access(1, 1'b0, 12'h010, 16'h0, eh, er);
        do_access(1, 1'b0, 12'h010, 16'h0, rd, hit, cyc);
        checks++; if (hit !== 1'b1 || rd !== 16'hAAAA || oplog.size() != 0 || cyc != 1) begin
            errors++; $display("FAIL wt_no_alloc got hit=%b data=%h ops=%0d cyc=%0d required 1 aaaa 0 1", hit, rd, oplog.size(), cyc);
        end
    endtask

    task automatic test_flush();
        logic [15:0] rd, er; logic hit, eh; int cyc, pulses;
        logic [11:0] fa [3] = '{12'h000, 12'h07F, 12'h0FF};
        logic [15:0] fd [3] = '{16'hA000, 16'hA07F, 16'hA0FF};
        for (int k = 0; k < 3; k++) begin
            model_access(0, 1'b1, fa[k], fd[k], eh, er);
            do_access(0, 1'b1, fa[k], fd[k], rd, hit, cyc);
        end
        model_flush(0);
        do_flush(0, cyc, pulses);
        checks++; if (cyc < 0 || pulses != 1) begin
            errors++; $display("FAIL flush_done got cyc=%0d pulses=%0d required done with 1 pulse", cyc, pulses);
        end
        checks++; if (oplog.size() != 3) begin errors++; $display("FAIL flush_count got %0d writes required 3", oplog.size()); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (oplog[k] !== op(0, 1'b1, fa[k], fd[k])) begin
                errors++; $display("FAIL flush_order k=%0d got %h required %h", k, oplog[k], op(0, 1'b1, fa[k], fd[k]));
            end
        end
        for (int k = 0; k < 3; k++) begin
            model_access(0, 1'b0, fa[k], 16'h0, eh, er);
            do_access(0, 1'b0, fa[k], 16'h0, rd, hit, cyc);
            checks++; if (hit !== 1'b0 || rd !== fd[k]) begin
                errors++; $display("FAIL flush_reread k=%0d got hit=%b data=%h required hit=0 data=%h", k, hit, rd, fd[k]);
            end
        end
    endtask

    task automatic test_flush_vs_req();
        logic [15:0] rd, er; logic hit, eh; int cyc, fcyc; bit early;
        model_access(0, 1'b1, 12'h0AA, 16'h2222, eh, er);
        do_access(0, 1'b1, 12'h0AA, 16'h2222, rd, hit, cyc);
        model_flush(0);
        model_access(0, 1'b0, 12'h0AA, 16'h0, eh, er);
        @(negedge clk);
        oplog.delete();
        flush[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 12'h0AA; cpu_req[0] = 1'b1;
        fcyc = -1; early = 1'b0; cyc = -1; rd = '0; hit = 1'b0;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            if (cpu_ready[0]) early = 1'b1;
            if (flush_done[0]) begin fcyc = i; break; end
        end
        flush[0] = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (cpu_ready[0]) begin cyc = i; rd = cpu_rdata[0]; hit = cache_hit[0]; break; end
        end
        cpu_req[0] = 1'b0;
        checks++; if (fcyc < 0 || early) begin
            errors++; $display("FAIL fvr_flush_first got flush_cyc=%0d ready_before_done=%b required done first", fcyc, early);
        end
        checks++; if (cyc < 0 || hit !== 1'b0 || rd !== 16'h2222) begin
            errors++; $display("FAIL fvr_access got cyc=%0d hit=%b data=%h required served miss 2222", cyc, hit, rd);
        end
        checks++; if (oplog.size() != 2 || oplog[0] !== op(0, 1'b1, 12'h0AA, 16'h2222)
                      || oplog[1] !== op(0, 1'b0, 12'h0AA, 16'h0)) begin
            errors++; $display("FAIL fvr_ops got n=%0d %h %h required wr 0aa=2222 then rd 0aa", oplog.size(), oplog[0], oplog[1]);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [15:0] rd, er; logic hit, eh; int waited; bit seen_rdy;
        @(negedge clk);
        cpu_we[0] = 1'b0; cpu_addr[0] = 12'h333; cpu_req[0] = 1'b1;
        waited = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mem_req[0]) begin waited = i; break; end
        end
        clr = 1'b0;
        cpu_req[0] = 1'b0;
        model_reset();
        #1;
        checks++; if (waited < 0 || mem_req[0] !== 1'b0 || cpu_ready[0] !== 1'b0) begin
            errors++; $display("FAIL rst_mid_fill got waited=%0d req=%b rdy=%b required req seen then 0 0", waited, mem_req[0], cpu_ready[0]);
        end
        seen_rdy = 1'b0;
        repeat (2) begin @(negedge clk); if (cpu_ready[0]) seen_rdy = 1'b1; end
        clr = 1'b1;
        repeat (3) begin @(negedge clk); if (cpu_ready[0]) seen_rdy = 1'b1; end
        checks++; if (seen_rdy) begin errors++; $display("FAIL rst_abandon got cpu_ready=1 required none"); end
        model_access(0, 1'b0, 12'h333, 16'h0, eh, er);
        do_access(0, 1'b0, 12'h333, 16'h0, rd, hit, waited);
        checks++; if (hit !== 1'b0 || rd !== init_val(0, 12'h333) || oplog.size() != 1) begin
            errors++; $display("FAIL rst_reread got hit=%b data=%h ops=%0d required 0 %h 1", hit, rd, oplog.size(), init_val(0, 12'h333));
        end
    endtask

    task automatic test_random();
        logic [15:0] rd, er, d; logic hit, eh; logic [11:0] a; bit we; int cyc, pulses;
        for (int g = 0; g < 2; g++) begin
            for (int n = 0; n < 200; n++) begin
                if ($urandom_range(0, 24) == 0) begin
                    model_flush(g);
                    do_flush(g, cyc, pulses);
                    checks++; if (cyc < 0 || pulses != 1 || oplog.size() != exp_ops.size()) begin
                        errors++; $display("FAIL rand_flush g=%0d got cyc=%0d pulses=%0d writes=%0d required 1 pulse %0d writes",
                                           g, cyc, pulses, oplog.size(), exp_ops.size());
                    end
                end else begin
                    a  = {4'($urandom_range(0, 2)), 8'($urandom_range(0, 7))};
                    we = 1'($urandom_range(0, 1));
                    d  = 16'($urandom);
                    model_access(g, we, a, d, eh, er);
                    do_access(g, we, a, d, rd, hit, cyc);
                    checks++; if (cyc < 0) begin errors++; $display("FAIL rand_timeout g=%0d addr=%h got no ready required ready", g, a); end
                    checks++; if (hit !== eh) begin errors++; $display("FAIL rand_hit g=%0d we=%b addr=%h got %b required %b", g, we, a, hit, eh); end
                    if (!we) begin
                        checks++; if (rd !== er) begin errors++; $display("FAIL rand_rdata g=%0d addr=%h got %h required %h", g, a, rd, er); end
                    end
                    if (exp_ops.size() == 0) begin
                        checks++; if (cyc != 1) begin errors++; $display("FAIL rand_latency g=%0d addr=%h got %0d required 1", g, a, cyc); end
                    end
                    checks++; if (oplog.size() != exp_ops.size()) begin
                        errors++; $display("FAIL rand_opcount g=%0d we=%b addr=%h got %0d required %0d", g, we, a, oplog.size(), exp_ops.size());
                    end
                end
                for (int i = 0; i < exp_ops.size(); i++) begin
                    checks++; if (oplog[i] !== exp_ops[i]) begin
                        errors++; $display("FAIL rand_op g=%0d i=%0d got %h required %h", g, i, oplog[i], exp_ops[i]);
                    end
                end
            end
        end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL mem_stability got %0d changes while pending required 0", stab_err); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got no completion required finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_miss_hit();
        test_wb_alloc();
        test_wt();
        test_flush();
        test_flush_vs_req();
        test_reset_mid_fill();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
